// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
        return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Distributed-RAM storage for sync_fifo; the read port is registered by default
// and combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_r[raddr];
`else
    logic [DATA_WIDTH-1:0] rdata_r;

    // Registered read: loads on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (DATA_WIDTH < 1 || DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_geometry
        $error("sync_fifo: DATA_WIDTH must be >=1 and DEPTH a power of 2 >= 4");
    end
    if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
        $error("sync_fifo: almost-full/almost-empty threshold out of range");
    end

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_s;
    logic             overflow_r;
    logic             underflow_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             ovf_set_s;
    logic             udf_set_s;
    fifo_status_t     status_s;

    assign count_s = wr_ptr_r - rd_ptr_r;

    // Flags come only from registered pointers so they never see this cycle's requests.
    always_comb begin
        status_s              = '0;
        status_s.full         = (count_s == PTR_W'(DEPTH));
        status_s.empty        = (count_s == {PTR_W{1'b0}});
        status_s.almost_full  = (count_s >= PTR_W'(AFULL_THRESH));
        status_s.almost_empty = (count_s <= PTR_W'(AEMPTY_THRESH));
        status_s.overflow     = overflow_r;
        status_s.underflow    = underflow_r;
    end

    // Request qualification; flush swallows both requests and their errors.
    always_comb begin
        if (flush) begin
            wr_acc_s  = 1'b0;
            rd_acc_s  = 1'b0;
            ovf_set_s = 1'b0;
            udf_set_s = 1'b0;
        end else begin
            wr_acc_s  = wr_en && !status_s.full;
            rd_acc_s  = rd_en && !status_s.empty;
            ovf_set_s = wr_en && status_s.full;
            udf_set_s = rd_en && status_s.empty;
        end
    end

    // Binary pointers with one wrap bit; count is their modular difference.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Sticky error flags: a new error beats clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s | (overflow_r  & ~clr_err);
            underflow_r <= udf_set_s | (underflow_r & ~clr_err);
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (din),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (dout)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout_valid = !status_s.empty;
`else
    logic dout_valid_r;

    // One-cycle pulse marking the word just loaded into dout.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= rd_acc_s;
        end
    end

    assign dout_valid = dout_valid_r;
`endif

    assign full         = status_s.full;
    assign almost_full  = status_s.almost_full;
    assign empty        = status_s.empty;
    assign almost_empty = status_s.almost_empty;
    assign overflow     = status_s.overflow;
    assign underflow    = status_s.underflow;
    assign count        = count_s;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=24, DEPTH=16).
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [23:0] din = 24'h0;
    logic        full;
    logic        almost_full;
    logic        rd_en = 1'b0;
    logic [23:0] dout;
    logic        dout_valid;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_err = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int dv_pulses;

    sync_fifo #(
        .DATA_WIDTH    (24),
        .DEPTH         (16),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'd0);
        check({tag, ".empty"}, 32'(empty), 32'd1);
        check({tag, ".full"}, 32'(full), 32'd0);
        check({tag, ".aempty"}, 32'(almost_empty), 32'd1);
        check({tag, ".afull"}, 32'(almost_full), 32'd0);
        check({tag, ".dv"}, 32'(dout_valid), 32'd0);
        check({tag, ".ovf"}, 32'(overflow), 32'd0);
        check({tag, ".udf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_state("reset");

`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; din = 24'h0000AA;
        cycle();
        wr_en = 1'b0;
        check("fwft.dout", 32'(dout), 32'h0000AA);
        check("fwft.dv", 32'(dout_valid), 32'd1);
        check("fwft.count", 32'(count), 32'd1);
        cycle();
        check("fwft.hold", 32'(dout), 32'h0000AA);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("fwft.pop_empty", 32'(empty), 32'd1);
        check("fwft.pop_dv", 32'(dout_valid), 32'd0);
        check("fwft.udf", 32'(underflow), 32'd0);
`else
        // Fill and drain.
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; din = 24'(i);
            cycle();
            check($sformatf("fill.count%0d", i), 32'(count), 32'(i));
            check($sformatf("fill.afull%0d", i), 32'(almost_full), 32'(i >= 14));
            check($sformatf("fill.full%0d", i), 32'(full), 32'(i == 16));
            check($sformatf("fill.aempty%0d", i), 32'(almost_empty), 32'(i <= 2));
        end

        // Overflow, clear racing a new error, then plain clear.
        din = 24'hABCDEF;
        cycle();
        check("ovf.count", 32'(count), 32'd16);
        check("ovf.flag", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        cycle();
        check("ovf.set_wins", 32'(overflow), 32'd1);
        wr_en = 1'b0;
        cycle();
        clr_err = 1'b0;
        check("ovf.cleared", 32'(overflow), 32'd0);

        dv_pulses = 0;
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (dout_valid) dv_pulses++;
            check($sformatf("drain.dout%0d", i), 32'(dout), 32'(i));
            check($sformatf("drain.count%0d", i), 32'(count), 32'(16 - i));
        end
        rd_en = 1'b0;
        cycle();
        check("drain.dv_pulses", 32'(dv_pulses), 32'd16);
        check("drain.dv_low", 32'(dout_valid), 32'd0);
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.dout_hold", 32'(dout), 32'd16);
        check("drain.udf", 32'(underflow), 32'd0);

        // Underflow with a simultaneous write.
        rd_en = 1'b1; wr_en = 1'b1; din = 24'h123456;
        cycle();
        rd_en = 1'b0; wr_en = 1'b0;
        check("udf.count", 32'(count), 32'd1);
        check("udf.flag", 32'(underflow), 32'd1);
        check("udf.dv", 32'(dout_valid), 32'd0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("udf.dout", 32'(dout), 32'h123456);
        check("udf.dv_read", 32'(dout_valid), 32'd1);
        check("udf.empty", 32'(empty), 32'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("udf.cleared", 32'(underflow), 32'd0);

        // Wrap and concurrency at constant fill level of 8.
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; din = 24'(32'h100 + k);
            cycle();
        end
        check("wrap.prefill", 32'(count), 32'd8);
        rd_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            din = 24'(32'h108 + j);
            cycle();
            check($sformatf("wrap.count%0d", j), 32'(count), 32'd8);
            check($sformatf("wrap.dout%0d", j), 32'(dout), 32'h100 + 32'(j));
        end
        rd_en = 1'b0;

        // Bring to 10 entries, then flush with a concurrent write.
        din = 24'h200;
        cycle();
        din = 24'h201;
        cycle();
        wr_en = 1'b0;
        check("flush.pre_count", 32'(count), 32'd10);
        flush = 1'b1; wr_en = 1'b1; din = 24'h3FF;
        cycle();
        flush = 1'b0; wr_en = 1'b0;
        check("flush.count", 32'(count), 32'd0);
        check("flush.empty", 32'(empty), 32'd1);
        check("flush.ovf", 32'(overflow), 32'd0);
        check("flush.udf", 32'(underflow), 32'd0);
        check("flush.dv", 32'(dout_valid), 32'd0);

        // Reset mid-stream at count=5 with a read pending.
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; din = 24'(32'h400 + k);
            cycle();
        end
        wr_en = 1'b0;
        check("rst.pre_count", 32'(count), 32'd5);
        rst = 1'b1; rd_en = 1'b1;
        cycle();
        rst = 1'b0; rd_en = 1'b0;
        check_reset_state("rst_mid");
        check("rst_mid.dout", 32'(dout), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised FIFO for intra-domain buffering: MIPI pixel words, control tokens, line buffers.
- Generalises the team's Gray-pointer FIFO family for the case with no CDC, so no synchronisers are used.
- Adds a fill-level count, programmable almost-full and almost-empty flags, sticky overflow and underflow errors, and a synchronous flush.
- Selectable first-word-fall-through read mode.

Parameters:
- DATA_WIDTH, 24: width of din and dout in bits; must be ≥1.
- DEPTH, 16: number of entries; must be a power of 2 and ≥4.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ this value; legal range 0..DEPTH-1.

Ports:
- clk, input, 1: single clock; all logic is posedge.
- rst, input, 1: synchronous reset, active-high.
- flush, input, 1: synchronous soft clear of pointers and count; memory is untouched.
- wr_en, input, 1: write request.
- din, input, DATA_WIDTH: write data.
- full, output, 1: no free entry.
- almost_full, output, 1: count ≥ AFULL_THRESH.
- rd_en, input, 1: read request in standard mode; acknowledge of the head word in FWFT mode.
- dout, output, DATA_WIDTH: read data.
- dout_valid, output, 1: dout holds a freshly read word.
- empty, output, 1: no stored entry.
- almost_empty, output, 1: count ≤ AEMPTY_THRESH.
- count, output, $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.
- clr_err, input, 1: clears overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- Pointers: ADDR_W+1 bits binary, where ADDR_W = $clog2(DEPTH). Address is the low ADDR_W bits; wrap from DEPTH-1 to 0 is natural.
- Derived flags:
  - count = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
  - full = (count == DEPTH); empty = (count == 0).
  - All four flags are combinational from registered pointers; no flag depends on the current cycle's wr_en or rd_en.
- Write acceptance: a write is accepted when wr_en && !full. Memory is written at wr_addr and wr_ptr increments.
- Read acceptance: a read is accepted when rd_en && !empty, and rd_ptr increments.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected, and overflow sets.
  - When empty: the write is accepted, the read is rejected, and underflow sets.
  - Otherwise both are accepted and count is unchanged.
- Standard mode read timing: dout is registered and updates the cycle after an accepted read. dout_valid pulses high for exactly that cycle. dout holds its value otherwise.
- Write-to-read latency: a write in cycle N deasserts empty in cycle N+1. An accepted read in N+1 presents data in N+2.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both are cleared only by clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Flush: pointers go to 0 next cycle, and dout_valid=0. Any wr_en or rd_en in the same cycle is ignored and raises no error flags. Error flags are not changed by flush.
- Priority: rst > flush > normal operation.
- Memory: distributed RAM style; no reset on storage.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (FWFT mode):
  - dout = mem[rd_addr] via combinational read from distributed RAM.
  - dout_valid = !empty.
  - rd_en acknowledges and pops the head word.
  - A write in cycle N shows on dout in N+1.
- Undefined: standard registered-read mode as described in Behaviour.
- Flags, count and error semantics are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - fifo_status_t struct {full, almost_full, empty, almost_empty, overflow, underflow}.
  - Function addr_w(depth).
  - Elaboration-time checks: power-of-2 DEPTH, threshold ranges.
- Sub-module sync_fifo_mem: distributed RAM with parameters DATA_WIDTH and DEPTH. One synchronous write port; one read port, registered or combinational per mode.
- Pointer, flag and error logic stay in sync_fifo.

Test Plan:
All scenarios use DATA_WIDTH=24, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2.
1. Fill and drain: write 0x000001..0x000010 in 16 consecutive cycles.
   - almost_full rises when count=14; full=1 at count=16.
   - Read 16 words: data returns in order; empty=1 after the last read; dout_valid pulses 16 times.
2. Overflow: at count=16, wr_en=1 with din=0xABCDEF.
   - count stays 16, overflow=1, and the word is not stored.
   - clr_err=1 clears overflow next cycle.
3. Underflow with simultaneous write: while empty, rd_en=1 and wr_en=1 with din=0x123456.
   - count=1, underflow=1, dout_valid=0.
   - The next read returns 0x123456.
4. Wrap and concurrency: pre-fill 8 words, then run wr_en=rd_en=1 for 40 cycles with an incrementing pattern.
   - count stays 8 throughout; the output sequence is contiguous across pointer wrap.
5. Flush:
   - At count=10 assert flush with wr_en=1: next cycle count=0, empty=1, no error flags.
   - rst mid-stream (count=5): all outputs return to reset values next cycle.
6. FWFT mode (SYNC_FIFO_FWFT_EN defined): write 0x0000AA.
   - Next cycle dout=0x0000AA and dout_valid=1 without rd_en.
   - rd_en=1 pops it: empty=1 and dout_valid=0 next cycle.
